half_adder_nand: RTL and testbench

- Bit-parallel half adder built strictly from two-input NAND gates, with registered outputs.
- Computes Sum = a XOR b and Cout = a AND b for each bit lane.
- Used as a leaf arithmetic cell and as a gate-level reference for adder/subtractor datapaths.
- Single clock domain. Asynchronous active-low reset.

---
 rtl/half_adder_nand.sv | 48 ++++
 tb/tb_half_adder_nand.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/half_adder_nand.sv
// Registered, bit-parallel half adder where every lane is built from five
// two-input NAND functions; each lane is independent, with no carry between lanes.
module half_adder_nand #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic [WIDTH-1:0] Cout,
  output logic             out_valid
);

  // The single primitive used for all lane logic.
  function automatic logic nand2(input logic x, input logic y);
    return ~&{x, y};
  endfunction

  logic [WIDTH-1:0] s_p0;
  logic [WIDTH-1:0] c_p0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic n1, n2, n3;
    assign n1      = nand2(a[i], b[i]);
    assign n2      = nand2(a[i], n1);
    assign n3      = nand2(b[i], n1);
    assign s_p0[i] = nand2(n2, n3);
    assign c_p0[i] = nand2(n1, n1);
  end

  // ---- p0 -> output register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sum       <= '0;
      Cout      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum  <= s_p0;
        Cout <= c_p0;
      end
    end
  end

endmodule

// File: tb/tb_half_adder_nand.sv
// Directed table, reset corner cases and a randomized run against an 8-lane half_adder_nand.
module tb_half_adder_nand;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic         in_valid;
  logic [W-1:0] Sum, Cout;
  logic         out_valid;

  int errors = 0;
  int checks = 0;

  half_adder_nand #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .Sum       (Sum),
    .Cout      (Cout),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         v;
    logic [W-1:0] s;
    logic [W-1:0] c;
    logic         ov;
  } vec_t;

  localparam int NVEC = 13;
  vec_t tbl [NVEC];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] es, input logic [W-1:0] ec,
                         input logic eov);
    chk({tag, ".Sum"}, Sum, es);
    chk({tag, ".Cout"}, Cout, ec);
    chk({tag, ".out_valid"}, {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, eov});
  endtask

  // Returns 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] ms, mc;
    logic         mov;

    // Truth table in every lane, multi-lane patterns, and hold cycles.
    tbl[0]  = '{a: 8'h00, b: 8'h00, v: 1'b1, s: 8'h00, c: 8'h00, ov: 1'b1};
    tbl[1]  = '{a: 8'h00, b: 8'hFF, v: 1'b1, s: 8'hFF, c: 8'h00, ov: 1'b1};
    tbl[2]  = '{a: 8'hFF, b: 8'h00, v: 1'b1, s: 8'hFF, c: 8'h00, ov: 1'b1};
    tbl[3]  = '{a: 8'hFF, b: 8'hFF, v: 1'b1, s: 8'h00, c: 8'hFF, ov: 1'b1};
    tbl[4]  = '{a: 8'hCC, b: 8'hAA, v: 1'b1, s: 8'h66, c: 8'h88, ov: 1'b1};
    tbl[5]  = '{a: 8'hA5, b: 8'h0F, v: 1'b0, s: 8'h66, c: 8'h88, ov: 1'b0};
    tbl[6]  = '{a: 8'hFF, b: 8'h00, v: 1'b1, s: 8'hFF, c: 8'h00, ov: 1'b1};
    tbl[7]  = '{a: 8'hFF, b: 8'hFF, v: 1'b0, s: 8'hFF, c: 8'h00, ov: 1'b0};
    tbl[8]  = '{a: 8'hFF, b: 8'hFF, v: 1'b0, s: 8'hFF, c: 8'h00, ov: 1'b0};
    tbl[9]  = '{a: 8'hFF, b: 8'hFF, v: 1'b0, s: 8'hFF, c: 8'h00, ov: 1'b0};
    tbl[10] = '{a: 8'hF0, b: 8'h3C, v: 1'b1, s: 8'hCC, c: 8'h30, ov: 1'b1};
    tbl[11] = '{a: 8'h5A, b: 8'hA5, v: 1'b1, s: 8'hFF, c: 8'h00, ov: 1'b1};
    tbl[12] = '{a: 8'h0C, b: 8'h0A, v: 1'b1, s: 8'h06, c: 8'h08, ov: 1'b1};

    // Reset: asserted between edges, then held across edges with live inputs.
    rst_n    = 1'b1;
    a        = 8'hFF;
    b        = 8'hFF;
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_all("rst_async", 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("rst_hold", 8'h00, 8'h00, 1'b0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      a        = tbl[i].a;
      b        = tbl[i].b;
      in_valid = tbl[i].v;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].s, tbl[i].c, tbl[i].ov);
    end

    // Mid-stream reset: pending capture is discarded, outputs clear at once.
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    step();
    chk_all("ms_11", 8'h00, 8'hFF, 1'b1);
    a = 8'h00; b = 8'hFF;
    step();
    chk_all("ms_01", 8'hFF, 8'h00, 1'b1);
    a = 8'hFF; b = 8'h00;
    #1 rst_n = 1'b0;
    #1 chk_all("ms_rst", 8'h00, 8'h00, 1'b0);
    #1 rst_n = 1'b1;
    #1 chk_all("ms_rel", 8'h00, 8'h00, 1'b0);
    step();
    chk_all("ms_after", 8'hFF, 8'h00, 1'b1);

    // Random run with a per-lane arithmetic model of the last accepted input.
    ms  = Sum;
    mc  = Cout;
    for (int n = 0; n < 1000; n++) begin
      a        = W'($urandom);
      b        = W'($urandom);
      in_valid = $urandom_range(0, 3) != 0;
      mov      = in_valid;
      if (in_valid) begin
        for (int i = 0; i < W; i++) begin
          logic [1:0] t;
          t     = {1'b0, a[i]} + {1'b0, b[i]};
          ms[i] = t[0];
          mc[i] = t[1];
        end
      end
      step();
      chk_all("rand", ms, mc, mov);
      chk("rand.exclusive", Sum & Cout, 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
